// File: rtl/result_monitor_pkg.sv
// Shared types and helpers for the result monitor: FSM state encoding,
// saturating accumulation and lowest-set-bit search.
package result_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Adds in 33 bits so that the carry out of a 32-bit counter is not lost.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

  function automatic int unsigned lowest_set(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/result_monitor_if.sv
// Bundle of run control, golden/actual sample buses and result outputs
// between a stimulus side (master) and the result monitor (slave).
interface result_monitor_if #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      start;
  logic                      en;
  logic [CHANNELS*WIDTH-1:0] exp;
  logic [CHANNELS*WIDTH-1:0] act;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [CNT_W-1:0]          err_cnt;
  logic                      err_any;
  logic [CH_W-1:0]           first_ch;
  logic [CNT_W-1:0]          first_idx;
  logic [WIDTH-1:0]          first_act;
  logic [WIDTH-1:0]          first_exp;

  modport master (
    output start, en, exp, act,
    input  busy, done, pass, err_cnt, err_any,
           first_ch, first_idx, first_act, first_exp
  );

  modport slave (
    input  start, en, exp, act,
    output busy, done, pass, err_cnt, err_any,
           first_ch, first_idx, first_act, first_exp
  );

endinterface

// File: rtl/result_monitor_sample_delay.sv
// LATENCY-deep register pipe that aligns golden samples with the DUT output;
// collapses to a wire when LATENCY is zero.
module sample_delay #(
  parameter int LATENCY = 1,
  parameter int DW      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          shift_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  if (LATENCY == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, clear_i, shift_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DW-1:0] pipe_q [LATENCY];

    // Clear has priority over shift so a restart never lets an old sample through.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (clear_i) begin
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (shift_i) begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[LATENCY-1];
  end

endmodule

// File: rtl/result_monitor.sv
// Compares delayed golden samples against DUT output per channel, counts
// mismatches, captures the first failure and reports pass/fail per run.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 1,
  parameter int SAMPLES  = 10000,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  result_monitor_if.slave mon
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW   = CHANNELS * WIDTH;
  localparam logic [31:0]      ERR_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(SAMPLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             any_q, any_d;
  logic [CH_W-1:0]  fch_q, fch_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [WIDTH-1:0] fact_q, fact_d;
  logic [WIDTH-1:0] fexp_q, fexp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic                dly_en;
  logic [DW-1:0]       dly_exp;
  logic                compare;
  logic [CHANNELS-1:0] mism;
  logic [31:0]         mism_cnt;
  int unsigned         first_k;

  sample_delay #(
    .LATENCY (LATENCY),
    .DW      (DW + 1)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clear_i (mon.start),
    .shift_i (state_q == ST_RUN),
    .d_i     ({mon.en, mon.exp}),
    .q_o     ({dly_en, dly_exp})
  );

  // A start in the same cycle as a compare drops that sample.
  assign compare = (state_q == ST_RUN) && dly_en && !mon.start;

  always_comb begin
    mism     = '0;
    mism_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mism[k]  = dly_exp[k*WIDTH +: WIDTH] != mon.act[k*WIDTH +: WIDTH];
      mism_cnt = mism_cnt + 32'(mism[k]);
    end
    first_k = lowest_set(32'(mism));
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    err_d   = err_q;
    any_d   = any_q;
    fch_d   = fch_q;
    fidx_d  = fidx_q;
    fact_d  = fact_q;
    fexp_d  = fexp_q;
    if (mon.start) begin
      state_d = ST_RUN;
      smp_d   = '0;
      err_d   = '0;
      any_d   = 1'b0;
      fch_d   = '0;
      fidx_d  = '0;
      fact_d  = '0;
      fexp_d  = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (compare) begin
            smp_d = smp_q + CNT_W'(1);
            err_d = CNT_W'(sat_add(32'(err_q), mism_cnt, ERR_MAX));
            if (!any_q && (mism != '0)) begin
              any_d  = 1'b1;
              fch_d  = CH_W'(first_k);
              fidx_d = smp_q;
              fact_d = mon.act[first_k*WIDTH +: WIDTH];
              fexp_d = dly_exp[first_k*WIDTH +: WIDTH];
            end
            if (smp_d == SAMPLES_C) state_d = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      smp_q   <= '0;
      err_q   <= '0;
      any_q   <= 1'b0;
      fch_q   <= '0;
      fidx_q  <= '0;
      fact_q  <= '0;
      fexp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      err_q   <= err_d;
      any_q   <= any_d;
      fch_q   <= fch_d;
      fidx_q  <= fidx_d;
      fact_q  <= fact_d;
      fexp_q  <= fexp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign mon.busy      = busy_q;
  assign mon.done      = done_q;
  assign mon.pass      = pass_q;
  assign mon.err_cnt   = err_q;
  assign mon.err_any   = any_q;
  assign mon.first_ch  = fch_q;
  assign mon.first_idx = fidx_q;
  assign mon.first_act = fact_q;
  assign mon.first_exp = fexp_q;

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: table-driven runs scored against a queue-based
// reference model, plus hand-written restart and async reset sequences.
module tb_result_monitor;

  localparam int W   = 3;
  localparam int CH  = 4;
  localparam int LAT = 1;
  localparam int NS  = 8;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_monitor_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) mon ();

  result_monitor #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .LATENCY  (LAT),
    .SAMPLES  (NS),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  typedef struct packed {
    logic [11:0] expV;
    logic [11:0] actV;
    logic [3:0]  errAfter;
  } vec_t;

  typedef struct {
    logic [11:0] expV;
    int          due;
  } sb_t;

  vec_t tab [NS];
  vec_t cleanTab [NS];
  sb_t  sbQ [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int mState, mCnt, mErr, mCh, mIdx, mFa, mFe;
  bit mAny;

  function automatic logic [11:0] pack4(input int a3, input int a2, input int a1, input int a0);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic modelClear();
    mCnt = 0; mErr = 0; mCh = 0; mIdx = 0; mFa = 0; mFe = 0; mAny = 1'b0;
    sbQ.delete();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("busy",      32'(mon.busy),      32'(mState == 1));
    checkOutput("done",      32'(mon.done),      32'(mState == 2));
    checkOutput("pass",      32'(mon.pass),      32'(mState == 2 && mErr == 0));
    checkOutput("err_cnt",   32'(mon.err_cnt),   32'(mErr));
    checkOutput("err_any",   32'(mon.err_any),   32'(mAny));
    checkOutput("first_ch",  32'(mon.first_ch),  32'(mCh));
    checkOutput("first_idx", 32'(mon.first_idx), 32'(mIdx));
    checkOutput("first_act", 32'(mon.first_act), 32'(mFa));
    checkOutput("first_exp", 32'(mon.first_exp), 32'(mFe));
  endtask

  // One clock cycle: drive inputs, advance the model to the coming edge, check after it.
  task automatic applyStimulus(input logic startV, input logic enV,
                               input logic [11:0] expV, input logic [11:0] actV);
    sb_t s;
    int  nm;
    int  fk;
    @(negedge clk);
    mon.start = startV;
    mon.en    = enV;
    mon.exp   = expV;
    mon.act   = actV;
    cyc++;
    if (startV) begin
      modelClear();
      mState = 1;
    end else if (mState == 1) begin
      if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
        s  = sbQ.pop_front();
        nm = 0;
        fk = -1;
        for (int k = 0; k < CH; k++) begin
          logic [2:0] ev, av;
          ev = s.expV[k*3 +: 3];
          av = actV[k*3 +: 3];
          if (ev != av) begin
            nm++;
            if (fk < 0) begin
              fk = k;
              if (!mAny) begin
                mCh = k; mFe = int'(ev); mFa = int'(av); mIdx = mCnt;
              end
            end
          end
        end
        if (nm > 0) mAny = 1'b1;
        mErr = (mErr + nm > SAT) ? SAT : mErr + nm;
        mCnt++;
        if (mCnt == NS) begin
          mState = 2;
          sbQ.delete();
        end
      end
      if (mState == 1 && enV) sbQ.push_back('{expV, cyc + 1});
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    mon.start = 1'b0; mon.en = 1'b0; mon.exp = '0; mon.act = '0;
    modelClear();
    mState = 0;
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample i is presented in cycle i; its DUT value follows one cycle later.
  task automatic runTable(input string tag);
    for (int i = 0; i <= NS; i++) begin
      applyStimulus(1'b0, i < NS, (i < NS) ? tab[i].expV : 12'h000,
                    (i > 0) ? tab[i-1].actV : 12'h000);
      if (i > 0)
        checkOutput($sformatf("%s_err%0d", tag, i - 1), 32'(mon.err_cnt), 32'(tab[i-1].errAfter));
    end
  endtask

  initial begin
    rst = 1'b1;
    mon.start = 1'b0; mon.en = 1'b0; mon.exp = '0; mon.act = '0;
    modelClear();
    mState = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",    32'(mon.busy),      32'd0);
    checkOutput("rst_done",    32'(mon.done),      32'd0);
    checkOutput("rst_pass",    32'(mon.pass),      32'd0);
    checkOutput("rst_err_cnt", 32'(mon.err_cnt),   32'd0);
    checkOutput("rst_err_any", 32'(mon.err_any),   32'd0);
    checkOutput("rst_first",   32'({mon.first_ch, mon.first_idx, mon.first_act, mon.first_exp}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NS; i++) begin
      cleanTab[i].expV     = pack4(i + 3, i + 2, i + 1, i);
      cleanTab[i].actV     = cleanTab[i].expV;
      cleanTab[i].errAfter = 4'd0;
    end

    $display("[TB] clean run");
    tab = cleanTab;
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    checkOutput("clean_busy_rise", 32'(mon.busy), 32'd1);
    runTable("clean");
    checkOutput("clean_done", 32'(mon.done), 32'd1);
    checkOutput("clean_pass", 32'(mon.pass), 32'd1);
    checkOutput("clean_busy", 32'(mon.busy), 32'd0);

    $display("[TB] single fault");
    tab = cleanTab;
    tab[5].expV = pack4(1, 5, 2, 7);
    tab[5].actV = pack4(1, 4, 2, 7);
    for (int i = 5; i < NS; i++) tab[i].errAfter = 4'd1;
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    checkOutput("single_done_clr", 32'(mon.done), 32'd0);
    runTable("single");
    checkOutput("single_err",   32'(mon.err_cnt),   32'd1);
    checkOutput("single_ch",    32'(mon.first_ch),  32'd2);
    checkOutput("single_idx",   32'(mon.first_idx), 32'd5);
    checkOutput("single_exp",   32'(mon.first_exp), 32'd5);
    checkOutput("single_act",   32'(mon.first_act), 32'd4);
    checkOutput("single_pass",  32'(mon.pass),      32'd0);
    checkOutput("single_done",  32'(mon.done),      32'd1);

    $display("[TB] multi-channel fault");
    tab = cleanTab;
    tab[0].actV = tab[0].expV ^ pack4(7, 0, 7, 0);
    tab[2].actV = tab[2].expV ^ pack4(0, 0, 0, 1);
    tab[0].errAfter = 4'd2;
    tab[1].errAfter = 4'd2;
    for (int i = 2; i < NS; i++) tab[i].errAfter = 4'd3;
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    runTable("multi");
    checkOutput("multi_err", 32'(mon.err_cnt),   32'd3);
    checkOutput("multi_ch",  32'(mon.first_ch),  32'd1);
    checkOutput("multi_idx", 32'(mon.first_idx), 32'd0);
    checkOutput("multi_exp", 32'(mon.first_exp), 32'd1);
    checkOutput("multi_act", 32'(mon.first_act), 32'd6);

    $display("[TB] saturation");
    tab = cleanTab;
    for (int i = 0; i < NS; i++) begin
      tab[i].actV     = ~tab[i].expV;
      tab[i].errAfter = 4'((4 * (i + 1) > SAT) ? SAT : 4 * (i + 1));
    end
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    runTable("sat");
    checkOutput("sat_err", 32'(mon.err_cnt), 32'd15);
    checkOutput("sat_ch",  32'(mon.first_ch), 32'd0);
    applyStimulus(1'b0, 1'b1, 12'h0F0, 12'h00F);
    checkOutput("sat_hold_done", 32'(mon.err_cnt), 32'd15);

    $display("[TB] restart and ignored enables");
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 12'hA5A, 12'h5A5);
    checkOutput("idle_err",  32'(mon.err_cnt), 32'd0);
    checkOutput("idle_busy", 32'(mon.busy),    32'd0);
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    applyStimulus(1'b0, 1'b1, cleanTab[0].expV, 12'h000);
    for (int i = 1; i < 4; i++)
      applyStimulus(1'b0, 1'b1, cleanTab[i].expV, ~cleanTab[i-1].expV);
    checkOutput("pre_restart_err", 32'(mon.err_cnt), 32'd12);
    applyStimulus(1'b1, 1'b1, cleanTab[4].expV, ~cleanTab[3].expV);
    checkOutput("restart_err",  32'(mon.err_cnt), 32'd0);
    checkOutput("restart_any",  32'(mon.err_any), 32'd0);
    checkOutput("restart_busy", 32'(mon.busy),    32'd1);
    tab = cleanTab;
    runTable("restart");
    checkOutput("restart_done", 32'(mon.done), 32'd1);
    checkOutput("restart_pass", 32'(mon.pass), 32'd1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 12'h123, 12'h321);
    checkOutput("done_ignore_err",  32'(mon.err_cnt), 32'd0);
    checkOutput("done_ignore_done", 32'(mon.done),    32'd1);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
    applyStimulus(1'b0, 1'b1, cleanTab[0].expV, 12'h000);
    for (int i = 1; i < 4; i++)
      applyStimulus(1'b0, 1'b1, cleanTab[i].expV, ~cleanTab[i-1].expV);
    checkOutput("pre_rst_err", 32'(mon.err_cnt), 32'd12);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy",    32'(mon.busy),    32'd0);
    checkOutput("arst_done",    32'(mon.done),    32'd0);
    checkOutput("arst_pass",    32'(mon.pass),    32'd0);
    checkOutput("arst_err_cnt", 32'(mon.err_cnt), 32'd0);
    checkOutput("arst_err_any", 32'(mon.err_any), 32'd0);
    checkOutput("arst_first",   32'({mon.first_ch, mon.first_idx, mon.first_act, mon.first_exp}), 32'd0);
    modelClear();
    mState = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 12'hFFF, 12'h000);
    checkOutput("post_rst_idle", 32'(mon.busy), 32'd0);
    checkOutput("post_rst_err",  32'(mon.err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
